// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter in front of a bank of JK flip-flop bits.
// One command accepted per cycle, applied one cycle later, answered with a tagged response.
module jk_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int NBITS = 8,
   parameter int AW    = $clog2(NBITS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*AW-1:0]        req_addr,
   input  logic [NREQ*2-1:0]         req_jk,
   input  logic                      bank_clr,
   output logic [NBITS-1:0]          q,
   output logic                      rsp_valid,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic                      rsp_q,
   output logic                      rsp_err
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_CLEAR  = 2'b01,
      JK_SET    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_cmd_e;

   logic [IW-1:0]    ptr;
   logic [IW-1:0]    win_id;
   logic [IW-1:0]    cand;
   logic             win_found;
   logic             xfer;

   logic             stg_valid;
   logic [IW-1:0]    stg_id;
   logic [AW-1:0]    stg_addr;
   jk_cmd_e          stg_jk;

   logic [NBITS-1:0] hit;
   logic [NBITS-1:0] q_next;
   logic             in_range;
   logic             cur_bit;
   logic             new_bit;

   // Scan requesters starting at ptr, wrapping modulo NREQ; first valid wins.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IW'((32'(ptr) + k) % NREQ);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (win_found && !reset && !bank_clr) begin
         req_ready[win_id] = 1'b1;
      end
   end

   assign xfer = |(req_valid & req_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr       <= '0;
         stg_valid <= 1'b0;
         stg_id    <= '0;
         stg_addr  <= '0;
         stg_jk    <= JK_HOLD;
      end else begin
         stg_valid <= xfer;
         if (xfer) begin
            stg_id   <= win_id;
            stg_addr <= req_addr[win_id*AW +: AW];
            stg_jk   <= jk_cmd_e'(req_jk[win_id*2 +: 2]);
            ptr      <= (win_id == IW'(NREQ - 1)) ? '0 : win_id + IW'(1);
         end
      end
   end

   // One-hot decode of the staged address; an empty decode marks an out-of-range address
   // and leaves the bank untouched without a separate magnitude compare.
   always_comb begin
      hit = '0;
      for (int unsigned i = 0; i < NBITS; i++) begin
         hit[i] = (stg_addr == AW'(i));
      end
      in_range = |hit;
      cur_bit  = |(q & hit);
      case (stg_jk)
         JK_HOLD:   new_bit = cur_bit;
         JK_CLEAR:  new_bit = 1'b0;
         JK_SET:    new_bit = 1'b1;
         JK_TOGGLE: new_bit = ~cur_bit;
         default:   new_bit = cur_bit;
      endcase
      q_next = (q & ~hit) | (hit & {NBITS{new_bit}});
   end

   // bank_clr wins over a staged command, which is dropped without a response.
   always_ff @(posedge clk) begin
      if (reset) begin
         q         <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_q     <= 1'b0;
         rsp_err   <= 1'b0;
      end else if (bank_clr) begin
         q         <= '0;
         rsp_valid <= 1'b0;
      end else begin
         rsp_valid <= stg_valid;
         if (stg_valid) begin
            q       <= q_next;
            rsp_id  <= stg_id;
            rsp_q   <= in_range & new_bit;
            rsp_err <= ~in_range;
         end
      end
   end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: a reference model predicts grants and responses,
// a separate monitor pops expectations whenever the DUT presents a response.
module tb_jk_bank_arbiter;

   localparam int NREQ  = 4;
   localparam int NBITS = 6;
   localparam int AW    = 3;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*2-1:0]    req_jk;
   logic                 bank_clr;
   logic [NBITS-1:0]     q;
   logic                 rsp_valid;
   logic [1:0]           rsp_id;
   logic                 rsp_q;
   logic                 rsp_err;

   jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_jk    (req_jk),
      .bank_clr  (bank_clr),
      .q         (q),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_q     (rsp_q),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               id;
      int               bitv;
      int               err;
      int               due;
      int               hs;
      logic [NBITS-1:0] snap;
   } exp_t;

   exp_t             sb[$];
   int               cyc    = 0;
   int               n_chk  = 0;
   int               n_pass = 0;

   logic [NBITS-1:0] mbank = '0;
   int               mptr  = 0;
   logic [NREQ-1:0]  m_er;
   int               m_w;
   int               m_a;
   int               m_jk;
   exp_t             m_e;
   exp_t             mon_e;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: grant prediction, bank contents and expected responses.
   always @(negedge clk) begin
      m_er = '0;
      m_w  = -1;
      if (reset || bank_clr) begin
         if (sb.size() > 0 && sb[sb.size()-1].hs == cyc - 1) void'(sb.pop_back());
         mbank = '0;
         if (reset) mptr = 0;
      end else begin
         for (int k = 0; k < NREQ; k++)
            if (m_w < 0 && req_valid[(mptr + k) % NREQ]) m_w = (mptr + k) % NREQ;
         if (m_w >= 0) begin
            m_er[m_w] = 1'b1;
            m_a  = int'(req_addr[m_w*AW +: AW]);
            m_jk = int'(req_jk[m_w*2 +: 2]);
            if (m_a < NBITS) begin
               case (m_jk)
                  1:       mbank[m_a] = 1'b0;
                  2:       mbank[m_a] = 1'b1;
                  3:       mbank[m_a] = ~mbank[m_a];
                  default: ;
               endcase
               m_e.bitv = int'(mbank[m_a]);
               m_e.err  = 0;
            end else begin
               m_e.bitv = 0;
               m_e.err  = 1;
            end
            m_e.id   = m_w;
            m_e.due  = cyc + 2;
            m_e.hs   = cyc;
            m_e.snap = mbank;
            sb.push_back(m_e);
            mptr = (m_w + 1) % NREQ;
         end
      end
      chk("req_ready", int'(req_ready), int'(m_er));
   end

   // Monitor: every DUT response must match the oldest expectation, on its due cycle.
   always @(negedge clk) begin
      if (rsp_valid) begin
         if (sb.size() == 0 || sb[0].due != cyc) begin
            chk("rsp_valid_unexpected", int'(rsp_valid), 0);
         end else begin
            mon_e = sb.pop_front();
            chk("rsp_id",  int'(rsp_id),  mon_e.id);
            chk("rsp_q",   int'(rsp_q),   mon_e.bitv);
            chk("rsp_err", int'(rsp_err), mon_e.err);
            chk("q_at_rsp", int'(q), int'(mon_e.snap));
         end
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
         chk("rsp_valid_missing", int'(rsp_valid), 1);
         void'(sb.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input bit v, input int a, input int jk);
      req_valid[i]          = v;
      req_addr[i*AW +: AW]  = AW'(a);
      req_jk[i*2 +: 2]      = 2'(jk);
   endtask

   task automatic idle(input int n);
      req_valid = '0;
      repeat (n) tick();
   endtask

   int jk_seq[5] = '{2, 3, 3, 1, 0};

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_addr  = '0;
      req_jk    = '0;
      bank_clr  = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      // Idle after reset
      for (int n = 0; n < 10; n++) begin
         tick();
         @(negedge clk);
         chk("idle_q", int'(q), 0);
         chk("idle_rsp_valid", int'(rsp_valid), 0);
      end

      // Single requester, same bit, back-to-back
      foreach (jk_seq[n]) begin
         tick();
         drive(0, 1'b1, 3, jk_seq[n]);
      end
      tick();
      idle(3);
      @(negedge clk);
      chk("seq_q", int'(q), 0);

      // Fairness with all requesters valid, starting from ptr=0
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < NREQ; i++) drive(i, 1'b1, i, 3);
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         chk("rr_grant", int'(req_ready), 1 << (n % NREQ));
         tick();
      end
      idle(3);
      @(negedge clk);
      chk("rr_q", int'(q), 0);

      // Pointer placement: grant 1 -> ptr=2, then 3 before 1, then 2 before 3
      tick();
      drive(1, 1'b1, 0, 0);
      @(negedge clk);
      chk("ptr_setup", int'(req_ready), 4'b0010);
      tick();
      drive(3, 1'b1, 1, 0);
      @(negedge clk);
      chk("ptr_first", int'(req_ready), 4'b1000);
      tick();
      @(negedge clk);
      chk("ptr_second", int'(req_ready), 4'b0010);
      tick();
      drive(1, 1'b0, 0, 0);
      drive(2, 1'b1, 2, 0);
      @(negedge clk);
      chk("ptr_new2", int'(req_ready), 4'b0100);
      tick();
      @(negedge clk);
      chk("ptr_then3", int'(req_ready), 4'b1000);
      tick();
      idle(3);

      // Reset in the middle of a stream drops the staged command
      drive(0, 1'b1, 1, 2);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req_valid = '0;
      @(negedge clk);
      chk("rst_q", int'(q), 0);
      idle(3);

      // Fill the bank, then clear while a toggle is staged
      for (int a = 0; a < NBITS; a++) begin
         tick();
         drive(0, 1'b1, a, 2);
      end
      tick();
      drive(0, 1'b1, 5, 3);
      tick();
      drive(0, 1'b0, 0, 0);
      drive(2, 1'b1, 0, 3);
      bank_clr = 1'b1;
      @(negedge clk);
      chk("clr_ready", int'(req_ready), 0);
      chk("clr_q_before", int'(q), 6'h3F);
      tick();
      bank_clr  = 1'b0;
      req_valid = '0;
      @(negedge clk);
      chk("clr_q_after", int'(q), 0);
      idle(3);

      // Out-of-range address, then a valid one
      tick();
      drive(1, 1'b1, 7, 2);
      tick();
      drive(1, 1'b1, 2, 2);
      tick();
      idle(3);
      @(negedge clk);
      chk("oor_q", int'(q), 6'b000100);

      // Randomized traffic with occasional clear and reset
      repeat (400) begin
         tick();
         req_valid = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = AW'($urandom_range(7));
            req_jk[i*2 +: 2]     = 2'($urandom_range(3));
         end
         bank_clr = ($urandom_range(19) == 0);
         reset    = ($urandom_range(49) == 0);
      end
      tick();
      bank_clr = 1'b0;
      reset    = 1'b0;
      idle(4);
      @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
